// File: rtl/inst_intensity_gen.sv
// Per-instrument visual envelope generator: latches hits during the frame, then
// once per frame refreshes or decays each instrument's level, one per cycle.
module inst_intensity_gen #(
  parameter int INSTRUMENT_COUNT = 3,
  parameter int UPDATE_LINE      = 720
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [10:0]                 h_count,
  input  logic [9:0]                  v_count,
  input  logic [INSTRUMENT_COUNT-1:0] hit,
  input  logic [6:0]                  hit_velocity [INSTRUMENT_COUNT],
  input  logic [9:0]                  decay,
  output logic [7:0]                  inst_intensity [INSTRUMENT_COUNT],
  output logic                        busy
);

  localparam int IDX_W = (INSTRUMENT_COUNT > 1) ? $clog2(INSTRUMENT_COUNT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(INSTRUMENT_COUNT - 1);

  typedef enum logic {IDLE, UPDATE} state_t;

  state_t                      state;
  logic [IDX_W-1:0]            idx;
  logic [6:0]                  level    [INSTRUMENT_COUNT];
  logic [6:0]                  pend_vel [INSTRUMENT_COUNT];
  logic [INSTRUMENT_COUNT-1:0] pending;
  logic [INSTRUMENT_COUNT-1:0] serve;
  logic [INSTRUMENT_COUNT-1:0] hit_ok;
  logic [6:0]                  cur_level;
  logic [6:0]                  decayed;
  logic                        tick;
  logic                        decay_unused;

  assign tick         = (h_count == 11'd0) && (v_count == 10'(UPDATE_LINE));
  assign decay_unused = ^decay[1:0];

  always_comb begin
    serve     = '0;
    hit_ok    = '0;
    cur_level = '0;
    for (int i = 0; i < INSTRUMENT_COUNT; i++) begin
      hit_ok[i] = hit[i] && (hit_velocity[i] != 7'd0);
      if (idx == IDX_W'(i)) begin
        cur_level = level[i];
        serve[i]  = (state == UPDATE);
      end
    end
  end

  // One shared 7x8 multiplier; the level is the top 7 bits of the 15-bit product.
  assign decayed = 7'(({8'd0, cur_level} * {7'd0, decay[9:2]}) >> 8);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      busy    <= 1'b0;
      pending <= '0;
      for (int i = 0; i < INSTRUMENT_COUNT; i++) begin
        level[i]          <= '0;
        pend_vel[i]       <= '0;
        inst_intensity[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (tick) begin
            state <= UPDATE;
            idx   <= '0;
            busy  <= 1'b1;
          end
        end
        UPDATE: begin
          if (idx == LAST_IDX) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
      endcase

      for (int i = 0; i < INSTRUMENT_COUNT; i++) begin
        if (serve[i]) begin
          pending[i] <= 1'b0;
          if (pending[i]) begin
            level[i]          <= pend_vel[i];
            inst_intensity[i] <= {1'b1, pend_vel[i]};
          end else begin
            level[i]          <= decayed;
            inst_intensity[i] <= {1'b0, decayed};
          end
        end
        // A hit landing on its own service slot starts a fresh pending entry.
        if (hit_ok[i]) begin
          pending[i] <= 1'b1;
          if (!(pending[i] && !serve[i] && (pend_vel[i] >= hit_velocity[i])))
            pend_vel[i] <= hit_velocity[i];
        end
      end
    end
  end

endmodule
